light_hash_gen: RTL and testbench

LIGHT_HASH_GEN -- requirements
Module: light_hash_gen

---
 rtl/light_hash_pkg.sv | 47 ++++
 rtl/aes_sbox.sv | 11 +
 rtl/light_hash_gen.sv | 148 ++++++++++++++
 tb/tb_light_hash_gen.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/light_hash_pkg.sv
// rtl/light_hash_pkg.sv - shared types and constant tables for the light hash generator
package light_hash_pkg;

  // FSM states for light_hash_gen
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ABSORB = 3'd1,
    ST_ROUND  = 3'd2,
    ST_FINAL  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam logic [7:0] START_BYTE = 8'hFF;
  localparam logic [7:0] END_BYTE   = 8'h00;

  // AES forward S-box
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Initial state bytes: IV[i] = SBOX(i)
  localparam logic [7:0] IV [32] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0
  };

  // Rotate a byte left by one bit
  function automatic logic [7:0] rotl1(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational 8-bit AES S-box lookup
module aes_sbox
  import light_hash_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/light_hash_gen.sv
// rtl/light_hash_gen.sv - byte-serial S-box sponge hash with start/end framing
module light_hash_gen
  import light_hash_pkg::*;
#(
  parameter int DIGEST_BYTES = 8,
  parameter int ROUNDS       = 4,
  parameter int ASCII_ONLY   = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                message_byte,
  input  logic                      message_valid,
  output logic                      message_ready,
  output logic [8*DIGEST_BYTES-1:0] digest,
  output logic                      digest_ready,
  output logic                      err_invalid_message_byte
);

  localparam int HW = 8 * DIGEST_BYTES;

  state_e          state_q, state_d;
  logic [HW-1:0]   h_q, h_d;
  logic [HW-1:0]   h_round;
  logic [7:0]      count_q, count_d;
  logic [4:0]      r_q, r_d;
  logic [7:0]      m_q, m_d;
  logic [HW-1:0]   digest_q, digest_d;
  logic            digest_ready_q, digest_ready_d;
  logic            err_q, err_d;

  logic [7:0]      rc;
  logic            accept;
  logic            byte_legal;
  logic            last_round;

  assign rc         = {3'b000, r_q} + 8'd1;
  assign last_round = (r_q == 5'(ROUNDS - 1));
  assign byte_legal = (ASCII_ONLY == 0) ||
                      ((message_byte >= 8'h20) && (message_byte <= 8'h7E));

  // Ready is a pure decode of the registered state, so offered bytes in ROUND/FINAL are dropped
  assign message_ready = (state_q == ST_IDLE) || (state_q == ST_ABSORB) || (state_q == ST_DONE);
  assign accept        = message_valid && message_ready;

  // One S-box lane per state byte; every lane mixes in its right neighbour rotated by one
  for (genvar i = 0; i < DIGEST_BYTES; i++) begin : g_lane
    logic [7:0] sb_in;
    logic [7:0] sb_out;
    logic [7:0] nb;
    assign sb_in = h_q[8*i +: 8] ^ m_q ^ rc;
    aes_sbox u_sbox (
      .in_byte  (sb_in),
      .out_byte (sb_out)
    );
    assign nb = h_q[8*((i + 1) % DIGEST_BYTES) +: 8];
    assign h_round[8*i +: 8] = sb_out ^ rotl1(nb);
  end

  // Next-state and datapath decisions for the framing FSM
  always_comb begin
    state_d        = state_q;
    h_d            = h_q;
    count_d        = count_q;
    r_d            = r_q;
    m_d            = m_q;
    digest_d       = digest_q;
    digest_ready_d = digest_ready_q;
    err_d          = err_q;

    if (accept && (message_byte == START_BYTE)) begin
      // A start byte restarts from any ready state and drops whatever was in flight
      for (int i = 0; i < DIGEST_BYTES; i++) begin
        h_d[8*i +: 8] = IV[i];
      end
      count_d        = 8'd0;
      digest_ready_d = 1'b0;
      err_d          = 1'b0;
      state_d        = ST_ABSORB;
    end else begin
      unique case (state_q)
        ST_ABSORB: begin
          if (accept) begin
            if (message_byte == END_BYTE) begin
              m_d     = count_q;
              r_d     = 5'd0;
              state_d = ST_FINAL;
            end else if (byte_legal) begin
              m_d     = message_byte;
              count_d = count_q + 8'd1;
              r_d     = 5'd0;
              state_d = ST_ROUND;
            end else begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
        ST_ROUND: begin
          h_d = h_round;
          r_d = r_q + 5'd1;
          if (last_round) begin
            state_d = ST_ABSORB;
          end
        end
        ST_FINAL: begin
          h_d = h_round;
          r_d = r_q + 5'd1;
          if (last_round) begin
            digest_d       = h_round;
            digest_ready_d = 1'b1;
            state_d        = ST_DONE;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      h_q            <= '0;
      count_q        <= 8'd0;
      r_q            <= 5'd0;
      m_q            <= 8'd0;
      digest_q       <= '0;
      digest_ready_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      h_q            <= h_d;
      count_q        <= count_d;
      r_q            <= r_d;
      m_q            <= m_d;
      digest_q       <= digest_d;
      digest_ready_q <= digest_ready_d;
      err_q          <= err_d;
    end
  end

  assign digest                   = digest_q;
  assign digest_ready             = digest_ready_q;
  assign err_invalid_message_byte = err_q;

endmodule

// File: tb/tb_light_hash_gen.sv
// tb/tb_light_hash_gen.sv - directed self-checking bench for light_hash_gen
module tb_light_hash_gen;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   mb [4];
  logic         mv [4];
  logic [3:0]   mr, dr, er;
  logic [63:0]  dg0, dg1;
  logic [15:0]  dg2;
  logic [255:0] dg3;

  int cmp_cnt = 0;
  int err_cnt = 0;

  logic [7:0]   tb_sbox [256];
  logic [7:0]   msg_q [$];
  logic [255:0] saved;

  always #5 clk = ~clk;

  light_hash_gen #(.DIGEST_BYTES(8), .ROUNDS(4), .ASCII_ONLY(0)) u0 (
    .clk(clk), .rst_n(rst_n), .message_byte(mb[0]), .message_valid(mv[0]),
    .message_ready(mr[0]), .digest(dg0), .digest_ready(dr[0]), .err_invalid_message_byte(er[0]));
  light_hash_gen #(.DIGEST_BYTES(8), .ROUNDS(4), .ASCII_ONLY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .message_byte(mb[1]), .message_valid(mv[1]),
    .message_ready(mr[1]), .digest(dg1), .digest_ready(dr[1]), .err_invalid_message_byte(er[1]));
  light_hash_gen #(.DIGEST_BYTES(2), .ROUNDS(1), .ASCII_ONLY(0)) u2 (
    .clk(clk), .rst_n(rst_n), .message_byte(mb[2]), .message_valid(mv[2]),
    .message_ready(mr[2]), .digest(dg2), .digest_ready(dr[2]), .err_invalid_message_byte(er[2]));
  light_hash_gen #(.DIGEST_BYTES(32), .ROUNDS(16), .ASCII_ONLY(0)) u3 (
    .clk(clk), .rst_n(rst_n), .message_byte(mb[3]), .message_valid(mv[3]),
    .message_ready(mr[3]), .digest(dg3), .digest_ready(dr[3]), .err_invalid_message_byte(er[3]));

  function automatic logic [255:0] dig(input int u);
    case (u)
      0:       return {192'b0, dg0};
      1:       return {192'b0, dg1};
      2:       return {240'b0, dg2};
      default: return dg3;
    endcase
  endfunction

  function automatic int n_of(input int u);
    return (u < 2) ? 8 : ((u == 2) ? 2 : 32);
  endfunction

  function automatic int r_of(input int u);
    return (u < 2) ? 4 : ((u == 2) ? 1 : 16);
  endfunction

  // GF(2^8) multiply with the AES polynomial
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box derived from field inverse plus affine map, independent of the RTL table
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        for (int y = 1; y < 256; y++) begin
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
        end
      end
      tb_sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  // Reference hash of msg_q for a given width and round count
  function automatic logic [255:0] model_hash(input int n, input int rr);
    logic [7:0]   h [32];
    logic [7:0]   hn [32];
    logic [7:0]   m;
    logic [7:0]   cnt;
    logic [7:0]   nb;
    logic [255:0] res;
    for (int i = 0; i < 32; i++) h[i] = (i < n) ? tb_sbox[i] : 8'h00;
    cnt = 8'h00;
    for (int k = 0; k <= msg_q.size(); k++) begin
      if (k < msg_q.size()) begin
        m = msg_q[k];
        cnt = cnt + 8'h01;
      end else begin
        m = cnt;
      end
      for (int r = 0; r < rr; r++) begin
        for (int i = 0; i < n; i++) begin
          nb = h[(i + 1) % n];
          hn[i] = tb_sbox[h[i] ^ m ^ 8'(r + 1)] ^ {nb[6:0], nb[7]};
        end
        for (int i = 0; i < n; i++) h[i] = hn[i];
      end
    end
    res = '0;
    for (int i = 0; i < n; i++) res[8*i +: 8] = h[i];
    return res;
  endfunction

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    cmp_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input string s);
    msg_q.delete();
    for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
  endtask

  // Offer one byte on unit u once it is ready; returns 1 ns after the transfer edge
  task automatic send(input int u, input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    while (!mr[u] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!mr[u]) check_eq("ready_timeout", {255'b0, mr[u]}, 256'd1);
    mb[u] = b;
    mv[u] = 1'b1;
    @(posedge clk);
    #1;
    mv[u] = 1'b0;
  endtask

  task automatic wait_done(input int u);
    for (int t = 0; t < 2000 && !dr[u]; t++) begin
      @(posedge clk);
      #1;
    end
    check_eq("done_wait", {255'b0, dr[u]}, 256'd1);
  endtask

  task automatic run_msg(input int u, input string tag);
    send(u, 8'hFF);
    foreach (msg_q[k]) send(u, msg_q[k]);
    send(u, 8'h00);
    wait_done(u);
    check_eq(tag, dig(u), model_hash(n_of(u), r_of(u)));
  endtask

  initial begin
    string sweep [4];
    sweep[0] = "H4rdw4r3_Tr0j4n";
    sweep[1] = "AlessandroAndGiacomo";
    sweep[2] = "Nel mezzo del cammin di nostra vita mi ritrovai per una selva oscura";
    sweep[3] = "3.141592653589793238";

    for (int u = 0; u < 4; u++) begin
      mb[u] = 8'h00;
      mv[u] = 1'b0;
    end
    build_sbox();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    check_eq("rst_digest", dig(0), 256'd0);
    check_eq("rst_dready", {252'b0, dr}, 256'd0);
    check_eq("rst_err", {252'b0, er}, 256'd0);
    check_eq("rst_ready", {252'b0, mr}, 256'hF);

    // Bytes other than start in IDLE are ignored
    send(0, 8'h51);
    send(0, 8'h00);
    repeat (6) @(posedge clk);
    #1;
    check_eq("idle_ignore_ready", {255'b0, mr[0]}, 256'd1);
    check_eq("idle_ignore_dready", {255'b0, dr[0]}, 256'd0);
    check_eq("idle_ignore_err", {255'b0, er[0]}, 256'd0);

    // Single 'A' with cycle-exact ready and digest_ready timing
    send(0, 8'hFF);
    send(0, 8'h41);
    for (int j = 0; j < 4; j++) begin
      check_eq("round_ready_low", {255'b0, mr[0]}, 256'd0);
      @(posedge clk);
      #1;
    end
    check_eq("round_ready_back", {255'b0, mr[0]}, 256'd1);
    send(0, 8'h00);
    for (int j = 0; j < 4; j++) begin
      check_eq("final_ready_low", {255'b0, mr[0]}, 256'd0);
      check_eq("final_dready_low", {255'b0, dr[0]}, 256'd0);
      @(posedge clk);
      #1;
    end
    check_eq("final_dready_rise", {255'b0, dr[0]}, 256'd1);
    check_eq("final_ready_back", {255'b0, mr[0]}, 256'd1);
    load("A");
    check_eq("digest_A", dig(0), model_hash(8, 4));

    // Empty message
    load("");
    run_msg(0, "digest_empty");

    // Non-ASCII bytes are legal when ASCII_ONLY=0
    msg_q.delete();
    msg_q.push_back(8'hE8);
    msg_q.push_back(8'h01);
    msg_q.push_back(8'hFE);
    run_msg(0, "digest_binary");

    // Bytes held valid through ROUND are dropped
    send(0, 8'hFF);
    @(negedge clk);
    mb[0] = 8'h41;
    mv[0] = 1'b1;
    @(posedge clk);
    #1;
    mb[0] = 8'h5A;
    repeat (4) @(posedge clk);
    #1;
    mv[0] = 1'b0;
    check_eq("hold_ready_back", {255'b0, mr[0]}, 256'd1);
    send(0, 8'h00);
    wait_done(0);
    load("A");
    check_eq("digest_hold", dig(0), model_hash(8, 4));

    // Mid-message restart keeps only the second message
    send(0, 8'hFF);
    send(0, 8'h71);
    send(0, 8'h72);
    load("st");
    run_msg(0, "digest_restart");

    // 256 bytes wrap the count back to zero
    msg_q.delete();
    for (int i = 0; i < 256; i++) msg_q.push_back(8'h78);
    run_msg(0, "digest_wrap256");

    // ASCII filter: abort keeps old digest, start clears the error
    load("Hi");
    run_msg(1, "digest_ascii_Hi");
    saved = model_hash(8, 4);
    send(1, 8'hFF);
    send(1, 8'h61);
    send(1, 8'hE8);
    check_eq("ascii_err_set", {255'b0, er[1]}, 256'd1);
    check_eq("ascii_idle_ready", {255'b0, mr[1]}, 256'd1);
    check_eq("ascii_digest_hold", dig(1), saved);
    send(1, 8'h00);
    repeat (6) @(posedge clk);
    #1;
    check_eq("ascii_idle_no_done", {255'b0, dr[1]}, 256'd0);
    check_eq("ascii_err_sticky", {255'b0, er[1]}, 256'd1);
    send(1, 8'hFF);
    check_eq("ascii_err_clear", {255'b0, er[1]}, 256'd0);

    // Width/round sweeps
    for (int s = 0; s < 4; s++) begin
      load(sweep[s]);
      run_msg(2, $sformatf("sweep_n2_%0d", s));
      run_msg(3, $sformatf("sweep_n32_%0d", s));
    end

    // Reset during ROUND discards the message
    send(0, 8'hFF);
    send(0, 8'h42);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("arst_digest", dig(0), 256'd0);
    check_eq("arst_dready", {255'b0, dr[0]}, 256'd0);
    check_eq("arst_ready", {255'b0, mr[0]}, 256'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_eq("arst_no_done", {255'b0, dr[0]}, 256'd0);
    check_eq("arst_digest_after", dig(0), 256'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
